// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare predictor: lane/XLEN defaults, counter encodings, EX packet.
`ifndef N
`define N 3
`endif
`ifndef XLEN
`define XLEN 32
`endif

package gshare_predictor_pkg;

  localparam int unsigned XLEN_W    = `XLEN;
  localparam int unsigned CTR_W     = 2;
  localparam int unsigned PKT_GHR_W = 8;

  // 2-bit counter encodings; MSB set means predict taken
  localparam logic [CTR_W-1:0] SNT = 2'b00;
  localparam logic [CTR_W-1:0] WNT = 2'b01;
  localparam logic [CTR_W-1:0] WT  = 2'b10;
  localparam logic [CTR_W-1:0] ST  = 2'b11;

  // Resolved-branch payload carried from EX back to the predictor
  typedef struct packed {
    logic                 valid;
    logic [XLEN_W-1:0]    pc;
    logic [PKT_GHR_W-1:0] ghr;
    logic                 taken;
  } ex_gshare_packet_t;

  // Saturating 2-bit counter step
  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : CTR_W'(ctr + 2'd1);
    end
    return (ctr == SNT) ? SNT : CTR_W'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2^IDX_W saturating counters, N read ports, N ordered write ports.
module gshare_pht
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned N     = 1,
  parameter int unsigned IDX_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N-1:0][IDX_W-1:0]    rd_idx_i,
  output logic [N-1:0][CTR_W-1:0]    rd_ctr_o,
  input  logic [N-1:0]               wr_en_i,
  input  logic [N-1:0][IDX_W-1:0]    wr_idx_i,
  input  logic [N-1:0]               wr_taken_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] ctr_q [DEPTH];
  logic [CTR_W-1:0] ctr_d [DEPTH];

  // Reads see the registered table only, so a same-cycle write is not bypassed
  always_comb begin
    rd_ctr_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      rd_ctr_o[i] = ctr_q[rd_idx_i[i]];
    end
  end

  // Lanes update in ascending order; a later lane builds on an earlier lane's result
  always_comb begin
    ctr_d = ctr_q;
    for (int i = 0; i < int'(N); i++) begin
      if (wr_en_i[i]) begin
        ctr_d[wr_idx_i[i]] = ctr_next(ctr_d[wr_idx_i[i]], wr_taken_i[i]);
      end
    end
  end

  // Counter storage; reset puts every entry at weakly-not-taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctr_q <= '{default: WNT};
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Multi-lane gshare direction predictor with speculative global history and squash recovery.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned N     = `N,
  parameter int unsigned GHR_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N-1:0]              fetch_valid,
  input  logic [N-1:0][`XLEN-1:0]   fetch_pc,
  input  logic [N-1:0]              fetch_is_cond,
  output logic [N-1:0]              pred_taken,
  output logic [N-1:0][GHR_W-1:0]   pred_ghr,
  output logic [GHR_W-1:0]          spec_ghr,
  input  logic [N-1:0]              ex_update_en,
  input  logic [N-1:0][`XLEN-1:0]   ex_pc,
  input  logic [N-1:0][GHR_W-1:0]   ex_ghr,
  input  logic [N-1:0]              ex_taken,
  input  logic                      squash,
  input  logic [GHR_W-1:0]          squash_ghr,
  input  logic                      squash_taken
);

  logic [GHR_W-1:0]          spec_ghr_q;
  logic [GHR_W-1:0]          spec_ghr_d;
  logic [GHR_W-1:0]          hist_nt;
  logic [GHR_W-1:0]          hist;
  logic                      blocked;
  logic [N-1:0]              lane_cond;
  logic [N-1:0][GHR_W-1:0]   rd_idx;
  logic [N-1:0][GHR_W-1:0]   wr_idx;
  logic [N-1:0][CTR_W-1:0]   rd_ctr;
  logic                      unused_bits;

  assign lane_cond   = fetch_valid & fetch_is_cond;
  assign spec_ghr    = spec_ghr_q;
  assign unused_bits = ^{fetch_pc, ex_pc, squash_ghr};

  // Any lane that is really predicted only follows not-taken predecessors, so its
  // lookup history is spec_ghr shifted by zeros; this keeps indices free of predictions.
  always_comb begin
    hist_nt = spec_ghr_q;
    rd_idx  = '0;
    wr_idx  = '0;
    for (int i = 0; i < int'(N); i++) begin
      rd_idx[i] = fetch_pc[i][GHR_W+1:2] ^ hist_nt;
      wr_idx[i] = ex_pc[i][GHR_W+1:2] ^ ex_ghr[i];
      if (lane_cond[i]) begin
        hist_nt = {hist_nt[GHR_W-2:0], 1'b0};
      end
    end
  end

  // Per-lane predictions and history chain; lanes after a taken branch are squelched
  always_comb begin
    hist       = spec_ghr_q;
    blocked    = 1'b0;
    pred_taken = '0;
    pred_ghr   = '0;
    for (int i = 0; i < int'(N); i++) begin
      pred_ghr[i] = hist;
      if (lane_cond[i] && !blocked) begin
        pred_taken[i] = rd_ctr[i][CTR_W-1];
        hist          = {hist[GHR_W-2:0], rd_ctr[i][CTR_W-1]};
        blocked       = rd_ctr[i][CTR_W-1];
      end
    end
    if (reset) begin
      pred_taken = '0;
      pred_ghr   = '0;
    end
    spec_ghr_d = squash ? {squash_ghr[GHR_W-2:0], squash_taken} : hist;
  end

  // Speculative history register; squash recovery wins over fetch advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spec_ghr_q <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
    end
  end

  gshare_pht #(
    .N     (N),
    .IDX_W (GHR_W)
  ) u_pht (
    .clock      (clock),
    .reset      (reset),
    .rd_idx_i   (rd_idx),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (ex_update_en),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (ex_taken)
  );

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: reference model plus directed scenarios with literal expectations.
module tb_gshare_predictor;

  localparam int NL   = 3;
  localparam int GW   = 4;
  localparam int MASK = (1 << GW) - 1;

  logic                    clock;
  logic                    reset;
  logic [NL-1:0]           fetch_valid;
  logic [NL-1:0][31:0]     fetch_pc;
  logic [NL-1:0]           fetch_is_cond;
  logic [NL-1:0]           pred_taken;
  logic [NL-1:0][GW-1:0]   pred_ghr;
  logic [GW-1:0]           spec_ghr;
  logic [NL-1:0]           ex_update_en;
  logic [NL-1:0][31:0]     ex_pc;
  logic [NL-1:0][GW-1:0]   ex_ghr;
  logic [NL-1:0]           ex_taken;
  logic                    squash;
  logic [GW-1:0]           squash_ghr;
  logic                    squash_taken;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  // reference state
  int pht_m [1 << GW];
  int ghr_m;

  gshare_predictor #(.N(NL), .GHR_W(GW)) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_is_cond (fetch_is_cond),
    .pred_taken    (pred_taken),
    .pred_ghr      (pred_ghr),
    .spec_ghr      (spec_ghr),
    .ex_update_en  (ex_update_en),
    .ex_pc         (ex_pc),
    .ex_ghr        (ex_ghr),
    .ex_taken      (ex_taken),
    .squash        (squash),
    .squash_ghr    (squash_ghr),
    .squash_taken  (squash_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Walk the fetch group: predict each real conditional lane until one predicts taken.
  function automatic void model_predict(output logic [NL-1:0] pt,
                                        output logic [NL-1:0][GW-1:0] pg,
                                        output int nxt);
    int  h;
    bit  stop;
    int  idx;
    pt   = '0;
    pg   = '0;
    h    = ghr_m;
    stop = 0;
    for (int l = 0; l < NL; l++) begin
      pg[l] = GW'(h);
      if (fetch_valid[l] && fetch_is_cond[l] && !stop) begin
        idx   = ((int'(fetch_pc[l]) >> 2) & MASK) ^ h;
        pt[l] = (pht_m[idx] >= 2);
        h     = ((h << 1) | int'(pt[l])) & MASK;
        if (pt[l]) stop = 1;
      end
    end
    nxt = h;
    if (reset) begin
      pt  = '0;
      pg  = '0;
    end
  endfunction

  // Reference state update
  always @(posedge clock or posedge reset) begin
    logic [NL-1:0]         upt;
    logic [NL-1:0][GW-1:0] upg;
    int                    nx;
    int                    idx;
    if (reset) begin
      ghr_m = 0;
      for (int e = 0; e < (1 << GW); e++) pht_m[e] = 1;
    end else begin
      model_predict(upt, upg, nx);
      for (int l = 0; l < NL; l++) begin
        if (ex_update_en[l]) begin
          idx = ((int'(ex_pc[l]) >> 2) & MASK) ^ int'(ex_ghr[l]);
          if (ex_taken[l]) pht_m[idx] = (pht_m[idx] == 3) ? 3 : pht_m[idx] + 1;
          else             pht_m[idx] = (pht_m[idx] == 0) ? 0 : pht_m[idx] - 1;
        end
      end
      ghr_m = squash ? (((int'(squash_ghr) << 1) | int'(squash_taken)) & MASK) : nx;
    end
  end

  // Per-cycle comparison against the reference
  always @(negedge clock) begin
    logic [NL-1:0]         ept;
    logic [NL-1:0][GW-1:0] epg;
    int                    enx;
    if (chk_en) begin
      model_predict(ept, epg, enx);
      check("model pred_taken", 32'(pred_taken), 32'(ept));
      for (int l = 0; l < NL; l++) check("model pred_ghr", 32'(pred_ghr[l]), 32'(epg[l]));
      check("model spec_ghr", 32'(spec_ghr), 32'(ghr_m));
    end
  end

  task automatic clear_inputs();
    fetch_valid   = '0;
    fetch_pc      = '0;
    fetch_is_cond = '0;
    ex_update_en  = '0;
    ex_pc         = '0;
    ex_ghr        = '0;
    ex_taken      = '0;
    squash        = 1'b0;
    squash_ghr    = '0;
    squash_taken  = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic fetch0(input logic [31:0] pc);
    fetch_valid[0]   = 1'b1;
    fetch_is_cond[0] = 1'b1;
    fetch_pc[0]      = pc;
  endtask

  task automatic upd(input int l, input logic [31:0] pc, input logic [GW-1:0] g, input logic t);
    ex_update_en[l] = 1'b1;
    ex_pc[l]        = pc;
    ex_ghr[l]       = g;
    ex_taken[l]     = t;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1;

    // first fetch after reset: weakly-not-taken everywhere
    fetch0(32'h100);
    #2;
    check("reset pred_taken", 32'(pred_taken), 32'h0);
    check("reset pred_ghr0", 32'(pred_ghr[0]), 32'h0);
    check("reset spec_ghr", 32'(spec_ghr), 32'h0);
    step();

    // two taken updates to one index in a single cycle: 01 -> 11
    upd(0, 32'h100, 4'b0000, 1'b1);
    upd(1, 32'h100, 4'b0000, 1'b1);
    step();
    fetch0(32'h100);
    #2;
    check("double-update pred", 32'(pred_taken), 32'h1);
    check("double-update ghr", 32'(spec_ghr), 32'h0);
    step();

    // third taken saturates; restore history to zero with a squash
    upd(0, 32'h100, 4'b0000, 1'b1);
    squash = 1'b1; squash_ghr = 4'b0000; squash_taken = 1'b0;
    step();
    upd(0, 32'h100, 4'b0000, 1'b0);
    step();
    fetch0(32'h100);
    // steer history to 4'b0011 for the multi-lane case
    squash = 1'b1; squash_ghr = 4'b0001; squash_taken = 1'b1;
    #2;
    check("saturate pred", 32'(pred_taken), 32'h1);
    step();

    // three lanes: NT, T, then squelched
    fetch_valid = 3'b111; fetch_is_cond = 3'b111;
    fetch_pc[0] = 32'h100; fetch_pc[1] = 32'h18; fetch_pc[2] = 32'h200;
    #2;
    check("multi spec_ghr", 32'(spec_ghr), 32'h3);
    check("multi pred_ghr1", 32'(pred_ghr[1]), 32'h6);
    check("multi pred_taken", 32'(pred_taken), 32'h2);
    step();
    #1;
    check("multi next ghr", 32'(spec_ghr), 32'hd);

    // squash overrides same-cycle fetch advance
    fetch_valid = 3'b111; fetch_is_cond = 3'b111;
    fetch_pc[0] = 32'h100; fetch_pc[1] = 32'h18; fetch_pc[2] = 32'h200;
    squash = 1'b1; squash_ghr = 4'b1010; squash_taken = 1'b1;
    step();
    #1;
    check("squash ghr", 32'(spec_ghr), 32'h5);

    // lookup/update collision at index 5: old value now, new value next cycle
    fetch0(32'h100);
    upd(0, 32'h100, 4'b0101, 1'b1);
    squash = 1'b1; squash_ghr = 4'b0010; squash_taken = 1'b1;
    #1;
    check("collision old", 32'(pred_taken), 32'h0);
    step();
    fetch0(32'h100);
    #1;
    check("collision ghr", 32'(spec_ghr), 32'h5);
    check("collision new", 32'(pred_taken), 32'h1);
    step();

    // asynchronous reset pulse between edges
    fetch0(32'h100);
    #2 reset = 1'b1;
    #1;
    check("async spec_ghr", 32'(spec_ghr), 32'h0);
    check("async pred_taken", 32'(pred_taken), 32'h0);
    for (int l = 0; l < NL; l++) check("async pred_ghr", 32'(pred_ghr[l]), 32'h0);
    reset = 1'b0;
    #0.5;
    check("post-reset ctr", 32'(pred_taken), 32'h0);
    step();
    upd(0, 32'h100, 4'b0000, 1'b1);
    step();
    fetch0(32'h100);
    #2;
    check("post-reset 01->10", 32'(pred_taken), 32'h1);
    step();

    // mixed traffic checked by the reference
    for (int c = 0; c < 80; c++) begin
      fetch_valid   = NL'($urandom);
      fetch_is_cond = NL'($urandom);
      ex_update_en  = NL'($urandom);
      ex_taken      = NL'($urandom);
      for (int l = 0; l < NL; l++) begin
        fetch_pc[l] = 32'($urandom_range(0, 63)) << 2;
        ex_pc[l]    = 32'($urandom_range(0, 63)) << 2;
        ex_ghr[l]   = GW'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        squash       = 1'b1;
        squash_ghr   = GW'($urandom);
        squash_taken = 1'($urandom);
      end
      @(posedge clock);
      #1;
    end
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
